// File: rtl/tictactoe_pkg.sv
// Shared types and helpers for the tic-tac-toe input front end.
package tictactoe_pkg;

  localparam int CELLS = 9;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    WAIT_REL
  } in_state_t;

  // Returns the index of the highest set bit; only meaningful for one-hot input.
  function automatic logic [3:0] onehot_idx(input logic [CELLS-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < CELLS; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [CELLS-1:0] v);
    return (v != '0) && ((v & (v - 9'd1)) == '0);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser and counter debouncer for one active-low pushbutton,
// producing the clean level plus single-cycle press/release strobes.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press,
  output logic released
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q;
  logic             press_q, release_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      level_q   <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // values, so sync1_q -> sync2_q forms a real two-stage chain.
      sync1_q   <= btn_n;
      sync2_q   <= sync1_q;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        // Strobes are registered alongside the flip so they align with the new level.
        level_q   <= sync2_q;
        press_q   <= ~sync2_q;
        release_q <= sync2_q;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level    = level_q;
  assign press    = press_q;
  assign released = release_q;

endmodule

// File: rtl/move_input.sv
// Conditions the select/new-game buttons and position switches, and turns a
// clean select press into a validated single-cycle move (or error) pulse.
module move_input
  import tictactoe_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             select_n,
  input  logic             newgame_n,
  input  logic [CELLS-1:0] sw,
  input  logic             enable,
  output logic             move_valid,
  output logic [CELLS-1:0] move,
  output logic [3:0]       move_idx,
  output logic             move_err,
  output logic             newgame
);

  logic sel_level, sel_press, sel_release;
  logic ng_level, ng_press, ng_release;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_sel_db (
    .clk      (clk),
    .rst      (rst),
    .btn_n    (select_n),
    .level    (sel_level),
    .press    (sel_press),
    .released (sel_release)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ng_db (
    .clk      (clk),
    .rst      (rst),
    .btn_n    (newgame_n),
    .level    (ng_level),
    .press    (ng_press),
    .released (ng_release)
  );

  logic [CELLS-1:0] sw_sync1_q, sw_sync2_q;
  in_state_t        state_q;
  logic             move_valid_q, move_err_q, newgame_q;
  logic [CELLS-1:0] move_q;
  logic [3:0]       move_idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
    end else begin
      sw_sync1_q <= sw;
      sw_sync2_q <= sw_sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      move_valid_q <= 1'b0;
      move_err_q   <= 1'b0;
      newgame_q    <= 1'b0;
      move_q       <= '0;
      move_idx_q   <= '0;
    end else begin
      move_valid_q <= 1'b0;
      move_err_q   <= 1'b0;
      newgame_q    <= 1'b0;
      if (ng_press) begin
        // New game overrides any in-flight select, including one in SAMPLE.
        newgame_q  <= 1'b1;
        move_q     <= '0;
        move_idx_q <= '0;
        state_q    <= sel_level ? IDLE : WAIT_REL;
      end else begin
        unique case (state_q)
          IDLE: if (sel_press) state_q <= SAMPLE;
          SAMPLE: begin
            if (!is_onehot(sw_sync2_q)) begin
              move_err_q <= 1'b1;
            end else if (enable) begin
              move_valid_q <= 1'b1;
              move_q       <= sw_sync2_q;
              move_idx_q   <= onehot_idx(sw_sync2_q);
            end
            state_q <= WAIT_REL;
          end
          WAIT_REL: if (sel_release) state_q <= IDLE;
          default:  state_q <= IDLE;
        endcase
      end
    end
  end

  assign move_valid = move_valid_q;
  assign move_err   = move_err_q;
  assign newgame    = newgame_q;
  assign move       = move_q;
  assign move_idx   = move_idx_q;

endmodule
